// File: rtl/ws2812b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812b_pkg
//  Description : Shared state encoding, default bit timing and GRB bit-field
//                positions for the WS2812B ring driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812b_pkg;

    // Frame state encoding
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HIGH  = 2'd1;
    localparam logic [1:0] c_ST_LOW   = 2'd2;
    localparam logic [1:0] c_ST_LATCH = 2'd3;

    // Default ring geometry and timing (cycles of a 10 MHz clock)
    localparam int c_DEF_NUM_LEDS = 12;
    localparam int c_DEF_POS_W    = 4;
    localparam int c_DEF_T0H      = 4;
    localparam int c_DEF_T1H      = 8;
    localparam int c_DEF_TBIT     = 12;
    localparam int c_DEF_TRES     = 3000;

    // GRB word: G occupies the top byte and is sent first, B[0] is sent last
    localparam int c_G_MSB = 23;
    localparam int c_B_LSB = 0;

endpackage : ws2812b_pkg
`default_nettype wire

// File: rtl/ws2812b_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812b_bit_timer
//  Description : Produces the waveform of one WS2812B bit. A go pulse starts
//                a TBIT-cycle bit whose high phase is T1H or T0H cycles.
//                bit_done is asserted in the final cycle of the bit so that a
//                following bit can start with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_bit_timer
    import ws2812b_pkg::*;
#(
    parameter int T0H  = c_DEF_T0H,
    parameter int T1H  = c_DEF_T1H,
    parameter int TBIT = c_DEF_TBIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic bit_val,
    output logic line,
    output logic bit_done
);

    localparam int CNT_W = $clog2(TBIT);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;
    logic             r_line;

    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_high_len;

    // Last cycle of the bit and the high-phase length for the bit in flight
    always_comb begin
        w_last     = r_active && (r_cnt == CNT_W'(TBIT - 1));
        w_cnt_inc  = r_cnt + CNT_W'(1);
        w_high_len = r_bit ? CNT_W'(T1H) : CNT_W'(T0H);
    end

    // Cycle counter and registered line level; a new go takes priority so
    // back-to-back bits abut exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 1'b0;
            r_line   <= 1'b0;
        end else if (go) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= bit_val;
            r_line   <= 1'b1;
        end else if (r_active) begin
            if (w_last) begin
                r_active <= 1'b0;
                r_line   <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_inc;
                r_line   <= (w_cnt_inc < w_high_len);
            end
        end
    end

    assign line     = r_line;
    assign bit_done = w_last;

endmodule : ws2812b_bit_timer
`default_nettype wire

// File: rtl/ws2812b_ring_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812b_ring_driver
//  Description : Serialises one WS2812B frame for a ring of NUM_LEDS LEDs,
//                lighting only the LED at the latched position in the latched
//                GRB colour, followed by a TRES-cycle latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_ring_driver
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = c_DEF_NUM_LEDS,
    parameter int POS_W    = c_DEF_POS_W,
    parameter int T0H      = c_DEF_T0H,
    parameter int T1H      = c_DEF_T1H,
    parameter int TBIT     = c_DEF_TBIT,
    parameter int TRES     = c_DEF_TRES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [POS_W-1:0] position,
    input  logic [23:0]      colour,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    localparam int TMR_W = $clog2(TRES + 1);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;

    logic [POS_W-1:0]  r_pos;
    logic [23:0]       r_colour;
    logic [POS_W-1:0]  r_led_idx;
    logic [4:0]        r_bit_idx;
    logic [TMR_W-1:0]  r_tmr;
    logic              r_busy;
    logic              r_done;

    logic              w_start_ok;
    logic              w_line;
    logic              w_bit_done;
    logic              w_last_bit;
    logic              w_latch_end;
    logic              w_go;
    logic              w_go_bit;
    logic [POS_W-1:0]  w_nxt_led;
    logic [4:0]        w_nxt_bit;
    logic [POS_W-1:0]  w_src_pos;
    logic [23:0]       w_src_colour;

    // Bit waveform generator
    ws2812b_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_go),
        .bit_val  (w_go_bit),
        .line     (w_line),
        .bit_done (w_bit_done)
    );

    // Select the next bit to send; on a start the live inputs are used since
    // the latched copies only update at the same edge
    always_comb begin
        // A start in the done cycle is dropped so a frame ends cleanly
        w_start_ok  = (r_state == c_ST_IDLE) && start && !r_done;
        w_last_bit  = (r_bit_idx == 5'(c_B_LSB)) &&
                      (r_led_idx == POS_W'(NUM_LEDS - 1));
        w_latch_end = (r_state == c_ST_LATCH) && (r_tmr == TMR_W'(TRES - 1));
        w_go        = w_start_ok || (w_bit_done && !w_last_bit);

        w_src_pos    = w_start_ok ? position : r_pos;
        w_src_colour = w_start_ok ? colour   : r_colour;

        if (w_start_ok) begin
            w_nxt_led = '0;
            w_nxt_bit = 5'(c_G_MSB);
        end else if (r_bit_idx != 5'(c_B_LSB)) begin
            w_nxt_led = r_led_idx;
            w_nxt_bit = r_bit_idx - 5'd1;
        end else begin
            w_nxt_led = r_led_idx + POS_W'(1);
            w_nxt_bit = 5'(c_G_MSB);
        end

        // Out-of-range positions never match, giving an all-dark frame
        w_go_bit = (w_nxt_led == w_src_pos) ? w_src_colour[w_nxt_bit] : 1'b0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; HIGH/LOW follow the line level reported by the timer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = c_ST_HIGH;
                end
            end
            c_ST_HIGH: begin
                if (w_bit_done) begin
                    w_state_nxt = w_last_bit ? c_ST_LATCH : c_ST_HIGH;
                end else if (!w_line) begin
                    w_state_nxt = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (w_bit_done) begin
                    w_state_nxt = w_last_bit ? c_ST_LATCH : c_ST_HIGH;
                end
            end
            c_ST_LATCH: begin
                if (w_latch_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Frame parameters, LED/bit counters, latch timer and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos     <= '0;
            r_colour  <= '0;
            r_led_idx <= '0;
            r_bit_idx <= '0;
            r_tmr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_latch_end;

            if (w_start_ok) begin
                r_pos    <= position;
                r_colour <= colour;
                r_busy   <= 1'b1;
                r_tmr    <= '0;
            end

            if (w_go) begin
                r_led_idx <= w_nxt_led;
                r_bit_idx <= w_nxt_bit;
            end

            if (w_bit_done && w_last_bit) begin
                r_tmr <= '0;
            end else if (r_state == c_ST_LATCH) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_latch_end) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign led_out = w_line;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule : ws2812b_ring_driver
`default_nettype wire
